// File: rtl/cu_seq.sv
// cu_seq: instruction sequencer owning PC, IR, flags and the return-address stack.
// Interrupt support (ie flag, EI/DI/RETI semantics, irq entry) is built only when CU_IRQ_EN is defined.
module cu_seq #(
  parameter int              AW      = 16,
  parameter int              IW      = 32,
  parameter int              SD      = 8,
  parameter logic [AW-1:0]   RST_VEC = 16'h0000,
  parameter logic [AW-1:0]   IRQ_VEC = 16'h0040
) (
  input  logic          clk,
  input  logic          reset,
  output logic          fetch_req,
  output logic [AW-1:0] fetch_addr,
  input  logic          fetch_ack,
  input  logic [IW-1:0] instr,
  output logic [IW-1:0] ir,
  output logic          exec_req,
  input  logic          exec_ack,
  input  logic          exec_c,
  input  logic          exec_z,
  output logic [1:0]    flags,
  input  logic          irq,
  output logic          irq_ack,
  output logic [AW-1:0] pc,
  output logic          halted,
  output logic          fault
);

  localparam int IDXW = $clog2(SD);
  localparam int SPW  = IDXW + 1;
  localparam logic [SPW-1:0] SD_W = SPW'(SD);

  localparam logic [3:0] OPC_OP   = 4'h0;
  localparam logic [3:0] OPC_JMP  = 4'h1;
  localparam logic [3:0] OPC_JC   = 4'h2;
  localparam logic [3:0] OPC_JZ   = 4'h3;
  localparam logic [3:0] OPC_CALL = 4'h4;
  localparam logic [3:0] OPC_RET  = 4'h5;
  localparam logic [3:0] OPC_RETI = 4'h6;
`ifdef CU_IRQ_EN
  localparam logic [3:0] OPC_EI   = 4'h7;
  localparam logic [3:0] OPC_DI   = 4'h8;
`endif
  localparam logic [3:0] OPC_HALT = 4'hF;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_HALT   = 3'd3,
    ST_FAULT  = 3'd4
  } state_t;

  state_t          state_r, state_nx_s;
  logic [AW-1:0]   pc_r, pc_nx_s;
  logic [IW-1:0]   ir_r, ir_nx_s;
  logic [1:0]      flags_r, flags_nx_s;
  logic [SPW-1:0]  sp_r, sp_nx_s;
  logic            fault_r, fault_nx_s;
  logic            fetch_req_r, exec_req_r, irq_ack_r, halted_r;
  logic            irq_ack_nx_s;
  logic [AW-1:0]   stack_r [SD];

  logic [3:0]      opcode_s;
  logic [AW-1:0]   target_s;
  logic [IDXW-1:0] push_idx_s, pop_idx_s;
  logic            irq_window_s, stack_err_s;
  logic            push_a_s, push_b_s;
  logic [IDXW-1:0] idx_a_s, idx_b_s;
  logic [AW-1:0]   data_a_s, data_b_s;

`ifdef CU_IRQ_EN
  logic            ie_r, ie_nx_s;
`else
  logic            unused_s;
  assign unused_s = irq | irq_window_s;
`endif

  assign opcode_s   = ir_r[IW-1:IW-4];
  assign target_s   = ir_r[AW-1:0];
  assign push_idx_s = IDXW'(sp_r);
  assign pop_idx_s  = IDXW'(sp_r - SPW'(1'b1));

  // Next-state, stack and interrupt-entry decisions; a stack fault cancels every other update.
  always_comb begin
    state_nx_s   = state_r;
    pc_nx_s      = pc_r;
    ir_nx_s      = ir_r;
    flags_nx_s   = flags_r;
    sp_nx_s      = sp_r;
    fault_nx_s   = fault_r;
    irq_ack_nx_s = 1'b0;
    irq_window_s = 1'b0;
    stack_err_s  = 1'b0;
    push_a_s     = 1'b0;
    push_b_s     = 1'b0;
    idx_a_s      = push_idx_s;
    idx_b_s      = push_idx_s;
    data_a_s     = pc_r;
    data_b_s     = pc_r;
`ifdef CU_IRQ_EN
    ie_nx_s      = ie_r;
`endif
    case (state_r)
      ST_FETCH: begin
        if (fetch_req_r && fetch_ack) begin
          ir_nx_s    = instr;
          pc_nx_s    = pc_r + AW'(1'b1);
          state_nx_s = ST_DECODE;
        end else begin
          state_nx_s = ST_FETCH;
        end
      end
      ST_DECODE: begin
        state_nx_s   = ST_FETCH;
        irq_window_s = 1'b1;
        case (opcode_s)
          OPC_OP: begin
            state_nx_s   = ST_EXEC;
            irq_window_s = 1'b0;
          end
          OPC_JMP: pc_nx_s = target_s;
          OPC_JC:  pc_nx_s = flags_r[1] ? target_s : pc_r;
          OPC_JZ:  pc_nx_s = flags_r[0] ? target_s : pc_r;
          OPC_CALL: begin
            if (sp_r == SD_W) begin
              stack_err_s = 1'b1;
            end else begin
              push_a_s = 1'b1;
              sp_nx_s  = sp_r + SPW'(1'b1);
              pc_nx_s  = target_s;
            end
          end
          OPC_RET, OPC_RETI: begin
            if (sp_r == {SPW{1'b0}}) begin
              stack_err_s = 1'b1;
            end else begin
              sp_nx_s = sp_r - SPW'(1'b1);
              pc_nx_s = stack_r[pop_idx_s];
`ifdef CU_IRQ_EN
              ie_nx_s = (opcode_s == OPC_RETI) ? 1'b1 : ie_r;
`endif
            end
          end
`ifdef CU_IRQ_EN
          OPC_EI: ie_nx_s = 1'b1;
          OPC_DI: ie_nx_s = 1'b0;
`endif
          OPC_HALT: begin
            state_nx_s   = ST_HALT;
            irq_window_s = 1'b0;
          end
          default: pc_nx_s = pc_r;
        endcase
      end
      ST_EXEC: begin
        if (exec_req_r && exec_ack) begin
          flags_nx_s   = {exec_c, exec_z};
          state_nx_s   = ST_FETCH;
          irq_window_s = 1'b1;
        end else begin
          state_nx_s = ST_EXEC;
        end
      end
      ST_HALT:  irq_window_s = 1'b1;
      ST_FAULT: state_nx_s = ST_FAULT;
      default: begin
        state_nx_s = ST_FAULT;
        fault_nx_s = 1'b1;
      end
    endcase

`ifdef CU_IRQ_EN
    // ie_r is the pre-decode value, so an EI in this same cycle defers entry to the next boundary.
    if (irq_window_s && irq && ie_r && !stack_err_s) begin
      if (sp_nx_s == SD_W) begin
        stack_err_s = 1'b1;
      end else begin
        push_b_s     = 1'b1;
        idx_b_s      = IDXW'(sp_nx_s);
        data_b_s     = pc_nx_s;
        sp_nx_s      = sp_nx_s + SPW'(1'b1);
        pc_nx_s      = IRQ_VEC;
        ie_nx_s      = 1'b0;
        irq_ack_nx_s = 1'b1;
        state_nx_s   = ST_FETCH;
      end
    end else begin
      irq_ack_nx_s = 1'b0;
    end
`endif

    if (stack_err_s) begin
      state_nx_s   = ST_FAULT;
      fault_nx_s   = 1'b1;
      pc_nx_s      = pc_r;
      sp_nx_s      = sp_r;
      push_a_s     = 1'b0;
      push_b_s     = 1'b0;
      irq_ack_nx_s = 1'b0;
`ifdef CU_IRQ_EN
      ie_nx_s      = ie_r;
`endif
    end else begin
      fault_nx_s = fault_r | (state_nx_s == ST_FAULT);
    end
  end

  // Architectural state and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_FETCH;
      pc_r        <= RST_VEC;
      ir_r        <= {IW{1'b0}};
      flags_r     <= 2'b00;
      sp_r        <= {SPW{1'b0}};
      fault_r     <= 1'b0;
      fetch_req_r <= 1'b0;
      exec_req_r  <= 1'b0;
      irq_ack_r   <= 1'b0;
      halted_r    <= 1'b0;
`ifdef CU_IRQ_EN
      ie_r        <= 1'b0;
`endif
    end else begin
      state_r     <= state_nx_s;
      pc_r        <= pc_nx_s;
      ir_r        <= ir_nx_s;
      flags_r     <= flags_nx_s;
      sp_r        <= sp_nx_s;
      fault_r     <= fault_nx_s;
      fetch_req_r <= (state_nx_s == ST_FETCH);
      exec_req_r  <= (state_nx_s == ST_EXEC);
      irq_ack_r   <= irq_ack_nx_s;
      halted_r    <= (state_nx_s == ST_HALT);
`ifdef CU_IRQ_EN
      ie_r        <= ie_nx_s;
`endif
    end
  end

  // Return-stack storage; port B carries the interrupt push that can coincide with a CALL.
  always_ff @(posedge clk) begin
    if (!reset && push_a_s) stack_r[idx_a_s] <= data_a_s;
    if (!reset && push_b_s) stack_r[idx_b_s] <= data_b_s;
  end

  assign fetch_req  = fetch_req_r;
  assign fetch_addr = pc_r;
  assign pc         = pc_r;
  assign ir         = ir_r;
  assign exec_req   = exec_req_r;
  assign flags      = flags_r;
  assign irq_ack    = irq_ack_r;
  assign halted     = halted_r;
  assign fault      = fault_r;

endmodule

// File: tb/tb_cu_seq.sv
// tb_cu_seq: directed self-checking bench for cu_seq with a behavioural fetch/exec responder.
module tb_cu_seq;
  localparam int AW = 16;
  localparam int IW = 32;
  localparam int SD = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          fetch_req, exec_req, irq_ack, halted, fault;
  logic [AW-1:0] fetch_addr, pc;
  logic [IW-1:0] ir;
  logic [1:0]    flags;
  logic          fetch_ack = 1'b0, exec_ack = 1'b0;
  logic          exec_c = 1'b0, exec_z = 1'b0, irq = 1'b0;
  logic [IW-1:0] instr = 32'h0000_0000;

  logic [IW-1:0] imem [0:1023];
  int            fetch_wait = 0;
  logic          exec_hold = 1'b0;
  int            fcnt = 0;
  int            tests_run = 0;
  int            tests_failed = 0;

  cu_seq #(.AW(AW), .IW(IW), .SD(SD)) dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ack(fetch_ack), .instr(instr),
    .ir(ir), .exec_req(exec_req), .exec_ack(exec_ack), .exec_c(exec_c), .exec_z(exec_z),
    .flags(flags), .irq(irq), .irq_ack(irq_ack), .pc(pc), .halted(halted), .fault(fault)
  );

  initial forever #5 clk = ~clk;

  // Fetch responder: acks after fetch_wait extra cycles of a held request.
  initial forever begin
    @(negedge clk);
    if (fetch_req) begin
      fetch_ack = (fcnt >= fetch_wait);
      instr     = imem[fetch_addr[9:0]];
      fcnt++;
    end else begin
      fetch_ack = 1'b0;
      fcnt      = 0;
    end
  end

  // Exec responder: zero-wait ack unless held.
  initial forever begin
    @(negedge clk);
    exec_ack = exec_req && !exec_hold;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    irq   = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) imem[i] = 32'hF000_0000;
  endtask

  task automatic next_fetch(input string tag);
    logic prev;
    bit   found;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      prev = fetch_req;
      tick();
      if (fetch_req && !prev) found = 1'b1;
    end
    if (!found) check_eq({tag, " timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int   cnt;
    logic stable;

    clear_mem();
    reset = 1'b1;
    tick();
    tick();
    check_eq("rst fetch_req", fetch_req, 32'd0);
    check_eq("rst exec_req", exec_req, 32'd0);
    check_eq("rst pc", pc, 32'd0);
    check_eq("rst ir", ir, 32'd0);
    check_eq("rst flags", flags, 32'd0);
    check_eq("rst halt/fault/ack", {halted, fault, irq_ack}, 32'd0);

    // Straight-line OPs, exact cycle timing
    imem[0] = 32'h0000_0000; imem[1] = 32'h0000_0000; imem[2] = 32'h0000_0000;
    exec_c = 1'b1; exec_z = 1'b0;
    reset = 1'b0;
    tick();
    check_eq("op c1 fetch_req", fetch_req, 32'd1);
    check_eq("op c1 addr", fetch_addr, 32'd0);
    tick();
    check_eq("op c2 fetch_req", fetch_req, 32'd0);
    tick();
    check_eq("op c3 exec_req", exec_req, 32'd1);
    tick();
    check_eq("op c4 addr", fetch_addr, 32'd1);
    check_eq("op c4 flags", flags, 32'd2);
    exec_c = 1'b0; exec_z = 1'b1;
    tick(); tick(); tick();
    check_eq("op c7 addr", fetch_addr, 32'd2);
    check_eq("op c7 fetch_req", fetch_req, 32'd1);
    check_eq("op c7 flags", flags, 32'd1);

    // JZ taken after OP with z=1
    clear_mem();
    imem[0] = 32'h0000_0000;
    imem[1] = 32'h3000_0100;
    exec_c = 1'b0; exec_z = 1'b1;
    do_reset();
    next_fetch("jz f0");
    next_fetch("jz f1");
    check_eq("jz f1 addr", fetch_addr, 32'd1);
    next_fetch("jz f2");
    check_eq("jz taken addr", fetch_addr, 32'h100);
    check_eq("jz flags", flags, 32'd1);

    // JZ not taken (z=0), then JC taken (c=1)
    imem[2] = 32'h2000_0300;
    exec_c = 1'b1; exec_z = 1'b0;
    do_reset();
    next_fetch("jz2 f0");
    next_fetch("jz2 f1");
    next_fetch("jz2 f2");
    check_eq("jz not taken addr", fetch_addr, 32'd2);
    next_fetch("jc f3");
    check_eq("jc taken addr", fetch_addr, 32'h300);

    // CALL/RET
    clear_mem();
    imem[0]     = 32'h1000_0010;
    imem[16'h10] = 32'h4000_0200;
    imem[16'h200] = 32'h5000_0000;
    do_reset();
    next_fetch("call f0");
    next_fetch("call f1");
    check_eq("call site addr", fetch_addr, 32'h10);
    next_fetch("call f2");
    check_eq("call target addr", fetch_addr, 32'h200);
    next_fetch("call f3");
    check_eq("ret addr", fetch_addr, 32'h11);

    // SD+1 nested CALLs overflow
    clear_mem();
    for (int k = 0; k <= SD; k++) imem[2*k] = 32'h4000_0000 | 32'(2*k + 2);
    do_reset();
    for (int i = 0; i < 200 && !fault; i++) tick();
    check_eq("ovf fault", fault, 32'd1);
    check_eq("ovf pc", pc, 32'h11);
    check_eq("ovf halted", halted, 32'd0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (fetch_req) cnt++;
    end
    check_eq("ovf no fetch", cnt, 32'd0);

    // RET underflow
    clear_mem();
    imem[0] = 32'h5000_0000;
    do_reset();
    check_eq("unf fault after rst", fault, 32'd0);
    for (int i = 0; i < 6; i++) tick();
    check_eq("unf fault", fault, 32'd1);
    check_eq("unf pc", pc, 32'd1);
    check_eq("unf fetch_req", fetch_req, 32'd0);

    // EI / HALT / irq
    clear_mem();
    imem[0] = 32'h7000_0000;
    imem[1] = 32'hF000_0000;
    imem[2] = 32'h0000_0000;
    imem[16'h40] = 32'h6000_0000;
    exec_c = 1'b0; exec_z = 1'b0;
    do_reset();
    for (int i = 0; i < 30 && !halted; i++) tick();
    check_eq("halt halted", halted, 32'd1);
    check_eq("halt fetch_req", fetch_req, 32'd0);
    irq = 1'b1;
`ifdef CU_IRQ_EN
    cnt = 0;
    for (int i = 0; i < 10 && !irq_ack; i++) tick();
    check_eq("irq ack", irq_ack, 32'd1);
    check_eq("irq addr", fetch_addr, 32'h40);
    check_eq("irq halted", halted, 32'd0);
    tick();
    check_eq("irq ack pulse", irq_ack, 32'd0);
    irq = 1'b0;
    next_fetch("reti f");
    check_eq("reti addr", fetch_addr, 32'd2);
    irq = 1'b1;
    for (int i = 0; i < 20 && !irq_ack; i++) tick();
    check_eq("reti ie", irq_ack, 32'd1);
    check_eq("reti irq addr", fetch_addr, 32'h40);
    irq = 1'b0;
`else
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (irq_ack || !halted || fetch_req) cnt++;
    end
    check_eq("halt ignores irq", cnt, 32'd0);
    irq = 1'b0;
`endif

    // Fetch wait states, then reset during EXEC
    clear_mem();
    imem[0] = 32'h0000_0000;
    fetch_wait = 5;
    exec_hold = 1'b1;
    do_reset();
    tick();
    check_eq("wait c1 fetch_req", fetch_req, 32'd1);
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (!(fetch_req && fetch_addr == 16'h0000)) stable = 1'b0;
    end
    check_eq("wait stable", stable, 32'd1);
    tick();
    check_eq("wait drop", fetch_req, 32'd0);
    tick();
    check_eq("exec held", exec_req, 32'd1);
    reset = 1'b1;
    tick();
    check_eq("rst exec_req", exec_req, 32'd0);
    check_eq("rst exec pc", pc, 32'd0);
    check_eq("rst exec fetch_req", fetch_req, 32'd0);
    reset = 1'b0;
    fetch_wait = 0;
    exec_hold = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
